// File: rtl/bram_arbiter.sv
// Two-requester (fetch/data) arbiter driving a phased BRAM bus: enable, address, data, wait.
// Define BRAM_ARBITER_RR_EN for round-robin on contention; otherwise requester 0 has fixed priority.
module bram_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_i,
  input  logic [1:0]               we_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i  [2],
  input  logic [DATA_WIDTH-1:0]    wdata_i [2],
  output logic [1:0]               resp_o,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     read_en_o,
  output logic                     write_en_o,
  output logic                     address_on_o,
  output logic                     data_on_o,
  output logic [DATA_WIDTH-1:0]    bus_o,
  input  logic [DATA_WIDTH-1:0]    bus_i,
  input  logic                     resp_i,
  output logic                     busy_o,
  output logic                     grant_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] EN   = 3'd1;
  localparam logic [2:0] ADDR = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;

  logic [2:0]               state, state_nxt;
  logic                     winner;
  logic                     lat_we;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_wdata;

  wire start = (state == IDLE) && (|req_i);

`ifdef BRAM_ARBITER_RR_EN
  // last_grant resets to 1 so requester 0 wins the first contention.
  logic last_grant;

  always_comb begin
    winner = (req_i == 2'b11) ? ~last_grant : ~req_i[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= 1'b1;
    else if (start) last_grant <= winner;
  end
`else
  always_comb begin
    winner = ~req_i[0];
  end
`endif

  // NOTE: payload registers carry no reset; they are only observed on bus_o
  // after being loaded, so resetting them would cost routing for nothing.
  always_ff @(posedge clk) begin
    if (start) begin
      lat_we    <= we_i[winner];
      lat_addr  <= addr_i[winner];
      lat_wdata <= wdata_i[winner];
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_i) state_nxt = EN;
      EN:      state_nxt = ADDR;
      ADDR:    state_nxt = lat_we ? DATA : WAIT;
      DATA:    state_nxt = WAIT;
      WAIT:    if (resp_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state and response registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_o <= 1'b0;
      resp_o  <= 2'b00;
      rdata_o <= '0;
    end else begin
      state  <= state_nxt;
      resp_o <= 2'b00;
      if (start) grant_o <= winner;
      if (state == WAIT && resp_i) begin
        resp_o  <= grant_o ? 2'b10 : 2'b01;
        rdata_o <= bus_i;
      end
    end
  end

  // Strobes decode straight from the registered state, so they are one-hot by construction.
  always_comb begin
    read_en_o    = 1'b0;
    write_en_o   = 1'b0;
    address_on_o = 1'b0;
    data_on_o    = 1'b0;
    bus_o        = '0;
    case (state)
      EN: begin
        write_en_o = lat_we;
        read_en_o  = ~lat_we;
      end
      ADDR: begin
        address_on_o = 1'b1;
        bus_o        = DATA_WIDTH'(lat_addr);
      end
      DATA: begin
        data_on_o = 1'b1;
        bus_o     = lat_wdata;
      end
      default: ;
    endcase
  end

  assign busy_o = (state != IDLE);

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, bus/data width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, requester address width in bits, with ADDRESS_WIDTH <= DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_i[2], we_i[2]  input  1 each  per-requester request and write-enable (index 0 = fetch, 1 = data).
REQ-006 SHALL have ports addr_i[2]  input  ADDRESS_WIDTH each; wdata_i[2]  input  DATA_WIDTH each.
REQ-007 SHALL have ports resp_o[2]  output  1 each  completion pulse; rdata_o  output  DATA_WIDTH  read data.
REQ-008 SHALL have ports read_en_o, write_en_o, address_on_o, data_on_o  output  1  BRAM bus phase strobes.
REQ-009 SHALL have ports bus_o  output  DATA_WIDTH  multiplexed address/data; bus_i  input  DATA_WIDTH  BRAM read data; resp_i  input  1  BRAM done.
REQ-010 SHALL have ports busy_o  output  1  transaction in flight; grant_o  output  1  index of served requester.

Function
REQ-011 SHALL implement FSM states IDLE, EN, ADDR, DATA, WAIT.
REQ-012 IDLE: when any req_i is high, SHALL select a winner, latch its we/addr/wdata, set grant_o, go to EN the next cycle; otherwise stay in IDLE.
REQ-013 EN: SHALL assert write_en_o if the latched we is set, else read_en_o, for exactly one cycle, then go to ADDR.
REQ-014 ADDR: SHALL assert address_on_o and drive bus_o = zero-extended latched address for one cycle; next state DATA if write, else WAIT.
REQ-015 DATA: SHALL assert data_on_o and drive bus_o = latched wdata for one cycle, then go to WAIT.
REQ-016 WAIT: SHALL hold until resp_i is high; in that cycle SHALL pulse resp_o[grant_o] for one cycle with rdata_o = bus_i (registered), then return to IDLE.
REQ-017 Strobes SHALL be mutually exclusive; bus_o SHALL be 0 outside ADDR/DATA.
REQ-018 Minimum latency from req_i to resp_o SHALL be 4 cycles for a read and 5 for a write, plus BRAM wait cycles.
REQ-019 Request inputs SHALL be sampled only in IDLE; changes or deassertion of req_i mid-transaction SHALL be ignored, and the transaction SHALL complete with resp_o still pulsed.
REQ-020 A requester holding req_i after its resp_o SHALL be re-arbitrated in the following IDLE cycle (back-to-back, one idle cycle between transactions).
REQ-021 resp_i outside WAIT SHALL be ignored.
REQ-022 rdata_o SHALL hold its last value until the next response; on writes it SHALL be updated from bus_i regardless.
REQ-023 busy_o SHALL be high in all states except IDLE.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, all strobes, resp_o, busy_o, grant_o 0, bus_o 0, rdata_o 0.
REQ-025 Reset mid-transaction SHALL abort the transaction with no resp_o; the requester must re-issue.
REQ-026 The round-robin pointer (if present) SHALL reset to 1 so that requester 0 wins first.

Configuration
REQ-027 Macro BRAM_ARBITER_RR_EN defined: when both requesters are high in IDLE, the requester not granted last SHALL win; the pointer SHALL update on every grant.
REQ-028 BRAM_ARBITER_RR_EN undefined: requester 0 SHALL always win on contention; no pointer state SHALL exist.

Verification
REQ-029 Single read: req_i[0]=1, addr=0x1000, resp_i 2 cycles after ADDR, bus_i=0xDEADBEEF -> read_en 1 cycle, address_on with bus_o=0x1000, resp_o[0] pulse, rdata_o=0xDEADBEEF.
REQ-030 Single write: req_i[1]=1, we=1, addr=0x20, wdata=0xA5A5 -> write_en, address_on bus_o=0x20, data_on bus_o=0xA5A5, resp_o[1] after resp_i.
REQ-031 Contention: both requesting continuously -> fixed: grant 0,0,0...; with RR_EN: grant 0,1,0,1.
REQ-032 Mid-transaction drop: req_i[0] deasserted during ADDR -> transaction completes, resp_o[0] pulses once.
REQ-033 Reset: rst_n low during WAIT -> outputs 0 asynchronously, no resp_o, IDLE after release; fresh request served normally.
